// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and constants for the fetch queue stage: queue entry layout, FSM states,
// index/count widths for the default configuration and a next-sequential-PC helper.
package fetch_queue_stage_pkg;

  localparam int FQ_INSN_WIDTH  = 32;
  localparam int FQ_PC_WIDTH    = 32;
  localparam int FQ_QUEUE_DEPTH = 16;
  localparam int FQ_IDX_WIDTH   = $clog2(FQ_QUEUE_DEPTH);

  typedef logic [FQ_IDX_WIDTH-1:0] FetchQueueIndexPath;
  typedef logic [FQ_IDX_WIDTH:0]   FetchQueueCountPath;

  typedef struct packed {
    logic [FQ_PC_WIDTH-1:0]   pc;
    logic [FQ_INSN_WIDTH-1:0] insn;
    logic                     pred_taken;
    logic [FQ_PC_WIDTH-1:0]   pred_addr;
  } FetchQueueEntry;

  typedef enum logic {
    FQ_RUN  = 1'b0,
    FQ_MISS = 1'b1
  } FetchQueueState;

  function automatic logic [FQ_PC_WIDTH-1:0] fq_next_addr(input logic [FQ_PC_WIDTH-1:0] pc);
    return pc + FQ_PC_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Bus between the I-cache read stage, the fetch queue and pre-decode. Signal prefixes are
// from the queue's point of view. Perf signals exist only with FETCH_QUEUE_PERF_EN defined.
interface fetch_queue_stage_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEQ_WIDTH   = 4,
  parameter int QUEUE_DEPTH = 16,
  parameter int PC_WIDTH    = 32
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int IW    = fetch_queue_stage_pkg::FQ_INSN_WIDTH;

  // Handshakes: a group moves in on a cycle where any i_valid lane and o_in_ready are both 1;
  // pre-decode takes every o_valid lane on a cycle where i_out_ready is 1.
  logic                         i_clear;
  logic [FETCH_WIDTH-1:0]       i_valid;
  logic [FETCH_WIDTH*PC_WIDTH-1:0] i_pc;
  logic [FETCH_WIDTH*IW-1:0]    i_insn;
  logic [FETCH_WIDTH-1:0]       i_pred_taken;
  logic [FETCH_WIDTH*PC_WIDTH-1:0] i_pred_addr;
  logic                         i_ic_read_hit;
  logic                         o_in_ready;
  logic                         o_ic_miss_stall;
  logic [DEQ_WIDTH-1:0]         o_valid;
  logic [DEQ_WIDTH*PC_WIDTH-1:0] o_pc;
  logic [DEQ_WIDTH*IW-1:0]      o_insn;
  logic [DEQ_WIDTH-1:0]         o_pred_taken;
  logic [DEQ_WIDTH*PC_WIDTH-1:0] o_pred_addr;
  logic                         i_out_ready;
  logic [CNT_W-1:0]             o_occupancy;
  fetch_queue_stage_pkg::FetchQueueState o_dbg_state;
`ifdef FETCH_QUEUE_PERF_EN
  logic                         o_perf_ic_miss;
  logic                         o_perf_queue_full;
  logic [31:0]                  o_miss_count;
  logic [31:0]                  o_full_count;
`endif

  modport master (
    output i_clear, i_valid, i_pc, i_insn, i_pred_taken, i_pred_addr, i_ic_read_hit, i_out_ready,
    input  o_in_ready, o_ic_miss_stall, o_valid, o_pc, o_insn, o_pred_taken, o_pred_addr,
           o_occupancy, o_dbg_state
`ifdef FETCH_QUEUE_PERF_EN
    , input o_perf_ic_miss, o_perf_queue_full, o_miss_count, o_full_count
`endif
  );

  modport slave (
    input  i_clear, i_valid, i_pc, i_insn, i_pred_taken, i_pred_addr, i_ic_read_hit, i_out_ready,
    output o_in_ready, o_ic_miss_stall, o_valid, o_pc, o_insn, o_pred_taken, o_pred_addr,
           o_occupancy, o_dbg_state
`ifdef FETCH_QUEUE_PERF_EN
    , output o_perf_ic_miss, o_perf_queue_full, o_miss_count, o_full_count
`endif
  );

endinterface

// File: rtl/fetch_queue_stage_compactor.sv
// Combinational taken-branch truncation and compaction of one fetch group into contiguous
// slots (first survivor in slot 0), with the sequential/predicted target resolved per lane.
module fetch_queue_stage_compactor
  import fetch_queue_stage_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FETCH_WIDTH-1:0]               i_valid,
  input  logic [FETCH_WIDTH*FQ_PC_WIDTH-1:0]   i_pc,
  input  logic [FETCH_WIDTH*FQ_INSN_WIDTH-1:0] i_insn,
  input  logic [FETCH_WIDTH-1:0]               i_pred_taken,
  input  logic [FETCH_WIDTH*FQ_PC_WIDTH-1:0]   i_pred_addr,
  output FetchQueueEntry                       o_slot [FETCH_WIDTH],
  output logic [FETCH_WIDTH-1:0]               o_slot_valid,
  output logic [CNT_W-1:0]                     o_count
);

  always_comb begin
    int             pos;
    logic           cut;
    FetchQueueEntry ent;
    pos          = 0;
    cut          = 1'b0;
    ent          = '0;
    o_slot_valid = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) o_slot[k] = '0;
    // Once a valid predicted-taken lane is seen, every later lane is off the predicted path.
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (i_valid[i] && !cut) begin
        ent.pc         = i_pc[i*FQ_PC_WIDTH +: FQ_PC_WIDTH];
        ent.insn       = i_insn[i*FQ_INSN_WIDTH +: FQ_INSN_WIDTH];
        ent.pred_taken = i_pred_taken[i];
        ent.pred_addr  = i_pred_taken[i] ? i_pred_addr[i*FQ_PC_WIDTH +: FQ_PC_WIDTH]
                                         : fq_next_addr(i_pc[i*FQ_PC_WIDTH +: FQ_PC_WIDTH]);
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          if (k == pos) begin
            o_slot[k]       = ent;
            o_slot_valid[k] = 1'b1;
          end
        end
        pos = pos + 1;
        if (i_pred_taken[i]) cut = 1'b1;
      end
    end
    o_count = CNT_W'(pos);
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Decoupling fetch queue: I-cache miss FSM, circular instruction queue and in-order head
// window to pre-decode. Define FETCH_QUEUE_PERF_EN to add miss/full perf pulses and counters.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int DEQ_WIDTH   = 4,
  parameter int QUEUE_DEPTH = FQ_QUEUE_DEPTH
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_stage_if.slave fq_if
);

  localparam int IDX_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int FCNT_W = $clog2(FETCH_WIDTH + 1);

  FetchQueueEntry   r_mem [QUEUE_DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_occ;
  FetchQueueState   r_state;

  FetchQueueEntry    w_slot [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] w_slot_valid;
  logic [FCNT_W-1:0] w_grp_cnt;
  logic              w_group;
  logic              w_hit_ok;
  logic [CNT_W-1:0]  w_n_deq;
  logic [CNT_W-1:0]  w_free_after;
  logic              w_in_ready;
  logic              w_enq;
  logic [CNT_W-1:0]  w_n_enq;

  fetch_queue_stage_compactor #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .CNT_W       (FCNT_W)
  ) u_compactor (
    .i_valid      (fq_if.i_valid),
    .i_pc         (fq_if.i_pc),
    .i_insn       (fq_if.i_insn),
    .i_pred_taken (fq_if.i_pred_taken),
    .i_pred_addr  (fq_if.i_pred_addr),
    .o_slot       (w_slot),
    .o_slot_valid (w_slot_valid),
    .o_count      (w_grp_cnt)
  );

  assign w_group  = |fq_if.i_valid;
  assign w_hit_ok = !w_group || fq_if.i_ic_read_hit;

  always_comb begin
    w_n_deq = '0;
    if (!rst && !fq_if.i_clear && fq_if.i_out_ready)
      w_n_deq = (r_occ > CNT_W'(DEQ_WIDTH)) ? CNT_W'(DEQ_WIDTH) : r_occ;
  end

  // Space is judged after this cycle's pop and against a whole group, not its survivors.
  assign w_free_after = CNT_W'(QUEUE_DEPTH) - (r_occ - w_n_deq);
  assign w_in_ready   = !rst && !fq_if.i_clear && w_hit_ok &&
                        (w_free_after >= CNT_W'(FETCH_WIDTH));
  assign w_enq        = w_in_ready && w_group;
  assign w_n_enq      = w_enq ? CNT_W'(w_grp_cnt) : '0;

  always_ff @(posedge clk) begin
    if (rst || fq_if.i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
      r_state <= FQ_RUN;
    end else begin
      r_head <= r_head + IDX_W'(w_n_deq);
      r_tail <= r_tail + IDX_W'(w_n_enq);
      r_occ  <= r_occ + w_n_enq - w_n_deq;
      case (r_state)
        FQ_RUN:  if (w_group && !fq_if.i_ic_read_hit) r_state <= FQ_MISS;
        FQ_MISS: if (fq_if.i_ic_read_hit) r_state <= FQ_RUN;
        default: r_state <= FQ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (w_slot_valid[k]) r_mem[r_tail + IDX_W'(k)] <= w_slot[k];
      end
    end
  end

  for (genvar g = 0; g < DEQ_WIDTH; g++) begin : g_out
    logic [IDX_W-1:0] w_idx;
    assign w_idx = r_head + IDX_W'(g);
    assign fq_if.o_valid[g]      = (CNT_W'(g) < r_occ);
    assign fq_if.o_pred_taken[g] = r_mem[w_idx].pred_taken;
    assign fq_if.o_pc[g*FQ_PC_WIDTH +: FQ_PC_WIDTH]          = r_mem[w_idx].pc;
    assign fq_if.o_insn[g*FQ_INSN_WIDTH +: FQ_INSN_WIDTH]    = r_mem[w_idx].insn;
    assign fq_if.o_pred_addr[g*FQ_PC_WIDTH +: FQ_PC_WIDTH]   = r_mem[w_idx].pred_addr;
  end

  assign fq_if.o_in_ready      = w_in_ready;
  assign fq_if.o_ic_miss_stall = (r_state == FQ_MISS);
  assign fq_if.o_occupancy     = r_occ;
  assign fq_if.o_dbg_state     = r_state;

`ifdef FETCH_QUEUE_PERF_EN
  logic        w_miss_start;
  logic        w_full_reject;
  logic [31:0] r_miss_count;
  logic [31:0] r_full_count;

  assign w_miss_start  = !rst && !fq_if.i_clear && (r_state == FQ_RUN) &&
                         w_group && !fq_if.i_ic_read_hit;
  assign w_full_reject = !rst && !fq_if.i_clear && w_group && fq_if.i_ic_read_hit && !w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_count <= '0;
      r_full_count <= '0;
    end else begin
      if (w_miss_start && (r_miss_count != '1)) r_miss_count <= r_miss_count + 32'd1;
      if (w_full_reject && (r_full_count != '1)) r_full_count <= r_full_count + 32'd1;
    end
  end

  assign fq_if.o_perf_ic_miss    = w_miss_start;
  assign fq_if.o_perf_queue_full = w_full_reject;
  assign fq_if.o_miss_count      = r_miss_count;
  assign fq_if.o_full_count      = r_full_count;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-level model of the stage.
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  localparam int FW = 4;
  localparam int DW = 4;
  localparam int QD = 16;
  localparam int PW = 32;
  localparam int EW = $bits(FetchQueueEntry);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_stage_if #(.FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .QUEUE_DEPTH(QD), .PC_WIDTH(PW)) fq_if ();

  fetch_queue_stage #(.FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
    .clk   (clk),
    .rst   (rst),
    .fq_if (fq_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  bit            m_miss = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  always @(negedge clk) begin
    int unsigned    occ, n_deq, free_after, n_show;
    bit             grp, exp_ready;
    logic [DW-1:0]  exp_valid;
    FetchQueueEntry e;
    occ        = exp_q.size();
    grp        = |fq_if.i_valid;
    n_show     = (occ < DW) ? occ : DW;
    n_deq      = (!rst && !fq_if.i_clear && fq_if.i_out_ready) ? n_show : 0;
    free_after = QD - (occ - n_deq);
    exp_ready  = !rst && !fq_if.i_clear && (!grp || fq_if.i_ic_read_hit) && (free_after >= FW);
    exp_valid  = '0;
    for (int i = 0; i < DW; i++) if (i < n_show) exp_valid[i] = 1'b1;

    chk("occupancy", 64'(fq_if.o_occupancy), 64'(occ));
    chk("out_valid", 64'(fq_if.o_valid), 64'(exp_valid));
    chk("in_ready", 64'(fq_if.o_in_ready), 64'(exp_ready));
    chk("ic_miss_stall", 64'(fq_if.o_ic_miss_stall), 64'(m_miss));
    for (int i = 0; i < DW; i++) begin
      if (i < n_show) begin
        e = exp_q[i];
        chk("out_pc", 64'(fq_if.o_pc[i*PW +: PW]), 64'(e.pc));
        chk("out_insn", 64'(fq_if.o_insn[i*32 +: 32]), 64'(e.insn));
        chk("out_pred_taken", 64'(fq_if.o_pred_taken[i]), 64'(e.pred_taken));
        chk("out_pred_addr", 64'(fq_if.o_pred_addr[i*PW +: PW]), 64'(e.pred_addr));
      end
    end

    if (rst || fq_if.i_clear) begin
      exp_q.delete();
      m_miss = 1'b0;
    end else begin
      repeat (n_deq) void'(exp_q.pop_front());
      if (exp_ready && grp) begin
        for (int i = 0; i < FW; i++) begin
          if (fq_if.i_valid[i]) begin
            e.pc         = fq_if.i_pc[i*PW +: PW];
            e.insn       = fq_if.i_insn[i*32 +: 32];
            e.pred_taken = fq_if.i_pred_taken[i];
            e.pred_addr  = fq_if.i_pred_taken[i] ? fq_if.i_pred_addr[i*PW +: PW] : e.pc + 32'd4;
            exp_q.push_back(e);
            if (fq_if.i_pred_taken[i]) break;
          end
        end
      end
      if (!m_miss && grp && !fq_if.i_ic_read_hit) m_miss = 1'b1;
      else if (m_miss && fq_if.i_ic_read_hit)     m_miss = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [FW-1:0] v, input logic [PW-1:0] base, input logic [FW-1:0] tk,
                       input logic [PW-1:0] tgt, input logic hit, input logic ordy, input logic clr);
    fq_if.i_valid      = v;
    fq_if.i_pred_taken = tk;
    for (int i = 0; i < FW; i++) begin
      fq_if.i_pc[i*PW +: PW]        = base + PW'(4 * i);
      fq_if.i_insn[i*32 +: 32]      = $urandom;
      fq_if.i_pred_addr[i*PW +: PW] = tgt;
    end
    fq_if.i_ic_read_hit = hit;
    fq_if.i_out_ready   = ordy;
    fq_if.i_clear       = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_clear();
    drive('0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    drive('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("reset_occupancy", 64'(fq_if.o_occupancy), 64'd0);
    chk("reset_out_valid", 64'(fq_if.o_valid), 64'd0);
    chk("reset_in_ready", 64'(fq_if.o_in_ready), 64'd0);
    chk("reset_stall", 64'(fq_if.o_ic_miss_stall), 64'd0);
    rst = 1'b0;

    // full group, no branches
    drive(4'hF, 32'h100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t1_out_valid", 64'(fq_if.o_valid), 64'hF);
    chk("t1_pc0", 64'(fq_if.o_pc[0 +: 32]), 64'h100);
    chk("t1_pc3", 64'(fq_if.o_pc[96 +: 32]), 64'h10C);
    chk("t1_addr0", 64'(fq_if.o_pred_addr[0 +: 32]), 64'h104);
    drive('0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t1_drained", 64'(fq_if.o_occupancy), 64'd0);

    // taken branch in lane 1
    drive(4'hF, 32'h100, 4'b0010, 32'h200, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("t2_occupancy", 64'(fq_if.o_occupancy), 64'd2);
    chk("t2_out_valid", 64'(fq_if.o_valid), 64'h3);
    chk("t2_addr1", 64'(fq_if.o_pred_addr[32 +: 32]), 64'h200);
    chk("t2_taken1", 64'(fq_if.o_pred_taken[1]), 64'd1);
    idle_clear();

    // I-cache miss for 3 cycles, then hit
    drive(4'hF, 32'h300, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("t3_ready_miss", 64'(fq_if.o_in_ready), 64'd0);
    cyc();
    chk("t3_stall_on", 64'(fq_if.o_ic_miss_stall), 64'd1);
    repeat (2) begin
      drive(4'hF, 32'h300, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    drive(4'hF, 32'h300, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 chk("t3_ready_hit", 64'(fq_if.o_in_ready), 64'd1);
    cyc();
    chk("t3_stall_off", 64'(fq_if.o_ic_miss_stall), 64'd0);
    chk("t3_occupancy", 64'(fq_if.o_occupancy), 64'd4);
    idle_clear();

    // fill, reject, wrap
    for (int g = 0; g < 4; g++) begin
      drive(4'hF, 32'h100 + 32'(16 * g), 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    chk("t4_full", 64'(fq_if.o_occupancy), 64'd16);
    drive(4'hF, 32'h140, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 chk("t4_reject", 64'(fq_if.o_in_ready), 64'd0);
    cyc();
    chk("t4_still_full", 64'(fq_if.o_occupancy), 64'd16);
    drive(4'hF, 32'h140, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    #1 chk("t4_accept", 64'(fq_if.o_in_ready), 64'd1);
    cyc();
    chk("t4_occ_after", 64'(fq_if.o_occupancy), 64'd16);
    chk("t4_head_pc", 64'(fq_if.o_pc[0 +: 32]), 64'h110);
    for (int d = 0; d < 3; d++) begin
      drive('0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
      cyc();
    end
    chk("t4_wrap_pc", 64'(fq_if.o_pc[0 +: 32]), 64'h140);
    drive('0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t4_empty", 64'(fq_if.o_occupancy), 64'd0);

    // clear with 10 entries and a valid hit group
    drive(4'hF, 32'h500, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'hF, 32'h510, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'hF, 32'h520, 4'b0010, 32'h900, 1'b1, 1'b0, 1'b0); cyc();
    chk("t5_occ10", 64'(fq_if.o_occupancy), 64'd10);
    drive(4'hF, 32'h600, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    #1 chk("t5_ready_clear", 64'(fq_if.o_in_ready), 64'd0);
    cyc();
    chk("t5_occ0", 64'(fq_if.o_occupancy), 64'd0);
    chk("t5_valid0", 64'(fq_if.o_valid), 64'd0);

    // reset while 7 entries held in MISS
    drive(4'hF, 32'h700, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'hF, 32'h710, 4'b0100, 32'hA00, 1'b1, 1'b0, 1'b0); cyc();
    drive(4'hF, 32'h720, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t6_occ7", 64'(fq_if.o_occupancy), 64'd7);
    chk("t6_miss", 64'(fq_if.o_dbg_state), 64'(FQ_MISS));
    rst = 1'b1;
    drive(4'hF, 32'h730, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("t6_occ", 64'(fq_if.o_occupancy), 64'd0);
    chk("t6_stall", 64'(fq_if.o_ic_miss_stall), 64'd0);
    chk("t6_valid", 64'(fq_if.o_valid), 64'd0);
    chk("t6_ready", 64'(fq_if.o_in_ready), 64'd0);
    chk("t6_run", 64'(fq_if.o_dbg_state), 64'(FQ_RUN));
    rst = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [FW-1:0] v, tk;
      v   = ($urandom_range(0, 4) == 0) ? '0 : FW'($urandom);
      tk  = ($urandom_range(0, 2) == 0) ? FW'(1 << $urandom_range(0, FW - 1)) : '0;
      rst = ($urandom_range(0, 199) == 0);
      drive(v, $urandom & 32'hFFFF_FFFC, tk, $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 5), ($urandom_range(0, 49) == 0));
      cyc();
    end
    rst = 1'b0;
    drive('0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
